// File: rtl/axi_stream_checker_pkg.sv
// rtl/axi_stream_checker_pkg.sv - shared constants and helpers for the stream checker
// Contents: error-bit indices, flag width, byte-lane popcount.
package axi_stream_checker_pkg;

  localparam int ERR_W              = 5;
  localparam int ERR_VALID_DROP     = 0;
  localparam int ERR_PAYLOAD_CHANGE = 1;
  localparam int ERR_STRB_NO_KEEP   = 2;
  localparam int ERR_STALL_TIMEOUT  = 3;
  localparam int ERR_PKT_OVERLEN    = 4;

  // Widest supported TKEEP; narrower channels zero-extend into it.
  localparam int MAX_BYTE_W = 64;
  localparam int POP_W      = $clog2(MAX_BYTE_W + 1);

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_BYTE_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_BYTE_W; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/axi_stream_checker_if.sv
// rtl/axi_stream_checker_if.sv - bundled multi-channel stream signals
// Signals: tvalid/tready/tlast per channel, flattened tdata/tkeep/tstrb.
// Modports: master (source side), slave (sink side), monitor (all inputs).
interface axi_stream_checker_if #(
  parameter int NUM_CH = 2,
  parameter int BYTE_W = 4
);
  logic [NUM_CH-1:0]          tvalid;
  logic [NUM_CH-1:0]          tready;
  logic [NUM_CH*8*BYTE_W-1:0] tdata;
  logic [NUM_CH*BYTE_W-1:0]   tkeep;
  logic [NUM_CH*BYTE_W-1:0]   tstrb;
  logic [NUM_CH-1:0]          tlast;

  modport master  (output tvalid, tdata, tkeep, tstrb, tlast, input tready);
  modport slave   (input tvalid, tdata, tkeep, tstrb, tlast, output tready);
  modport monitor (input tvalid, tready, tdata, tkeep, tstrb, tlast);
endinterface

// File: rtl/axi_stream_checker_ch.sv
// rtl/axi_stream_checker_ch.sv - one channel of the passive stream checker
// Inputs : aclk, areset (sync, active-high), clr, one channel's stream signals.
// Outputs: err_flags (sticky), err_flags_nxt (next-state flags for the top's err_any),
//          beat/pkt/byte counters, in_packet.
module axi_stream_checker_ch
  import axi_stream_checker_pkg::*;
#(
  parameter int BYTE_W        = 4,
  parameter int CNT_W         = 32,
  parameter int MAX_STALL     = 16,
  parameter int MAX_PKT_BEATS = 256
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                clr,
  input  logic                tvalid,
  input  logic                tready,
  input  logic [8*BYTE_W-1:0] tdata,
  input  logic [BYTE_W-1:0]   tkeep,
  input  logic [BYTE_W-1:0]   tstrb,
  input  logic                tlast,
  output logic [ERR_W-1:0]    err_flags,
  output logic [ERR_W-1:0]    err_flags_nxt,
  output logic [CNT_W-1:0]    beat_count,
  output logic [CNT_W-1:0]    pkt_count,
  output logic [CNT_W-1:0]    byte_count,
  output logic                in_packet
);

  localparam int PAY_W = 8*BYTE_W + 2*BYTE_W + 1;
  localparam int ST_W  = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam int PB_W  = (MAX_PKT_BEATS > 0) ? $clog2(MAX_PKT_BEATS + 1) : 1;
  localparam int SUM_W = CNT_W + POP_W + 1;

  localparam logic [ST_W-1:0]  ST_MAX  = ST_W'(MAX_STALL);
  localparam logic [ST_W-1:0]  ST_ARM  = ST_W'(MAX_STALL - 1);
  localparam logic [PB_W-1:0]  PB_MAX  = PB_W'(MAX_PKT_BEATS);
  localparam logic [PB_W-1:0]  PB_LAST = PB_W'(MAX_PKT_BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic             hs;
  logic             stalled;
  logic [PAY_W-1:0] payload;
  logic [PAY_W-1:0] prev_payload;
  logic             prev_valid;
  logic             prev_ready;
  logic             hist_ok;
  logic [ST_W-1:0]  stall_cnt;
  logic [PB_W-1:0]  pkt_beats;
  logic [ERR_W-1:0] err_set;
  logic [SUM_W-1:0] byte_sum;
  logic [CNT_W-1:0] byte_nxt;

  assign hs      = tvalid & tready;
  assign stalled = tvalid & ~tready;
  assign payload = {tdata, tkeep, tstrb, tlast};

  // Saturating byte accumulate, computed wide enough that the carry is never lost.
  assign byte_sum = SUM_W'(byte_count) + SUM_W'(popcount(MAX_BYTE_W'(tkeep)));
  assign byte_nxt = (byte_sum > SUM_W'(CNT_SAT)) ? CNT_SAT : byte_sum[CNT_W-1:0];

  always_comb begin
    err_set = '0;
    // Rules that look at last cycle's handshake are masked until history is valid.
    err_set[ERR_VALID_DROP]     = hist_ok & prev_valid & ~prev_ready & ~tvalid;
    err_set[ERR_PAYLOAD_CHANGE] = hist_ok & prev_valid & ~prev_ready & tvalid &
                                  (payload != prev_payload);
    err_set[ERR_STRB_NO_KEEP]   = tvalid & (|(tstrb & ~tkeep));
    // Fires only on the cycle the counter steps onto MAX_STALL; saturation then
    // keeps it from re-firing within the same stall episode.
    err_set[ERR_STALL_TIMEOUT]  = (MAX_STALL > 0) && stalled && (stall_cnt == ST_ARM);
    err_set[ERR_PKT_OVERLEN]    = (MAX_PKT_BEATS > 0) && hs && !tlast &&
                                  (pkt_beats == PB_LAST);
  end

  // clr drops old flags but keeps anything detected in the same cycle.
  assign err_flags_nxt = clr ? err_set : (err_flags | err_set);

  always_ff @(posedge aclk) begin
    if (areset) begin
      hist_ok      <= 1'b0;
      prev_valid   <= 1'b0;
      prev_ready   <= 1'b0;
      prev_payload <= '0;
      stall_cnt    <= '0;
      pkt_beats    <= '0;
      in_packet    <= 1'b0;
      err_flags    <= '0;
      beat_count   <= '0;
      pkt_count    <= '0;
      byte_count   <= '0;
    end else begin
      hist_ok      <= 1'b1;
      prev_valid   <= tvalid;
      prev_ready   <= tready;
      prev_payload <= payload;
      err_flags    <= err_flags_nxt;

      if (!stalled) begin
        stall_cnt <= '0;
      end else if (stall_cnt != ST_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end

      if (hs) begin
        in_packet <= ~tlast;
        if (tlast) begin
          pkt_beats <= '0;
        end else if (pkt_beats != PB_MAX) begin
          pkt_beats <= pkt_beats + 1'b1;
        end
      end

      // clr beats a same-cycle handshake: the beat is not counted.
      if (clr) begin
        beat_count <= '0;
        pkt_count  <= '0;
        byte_count <= '0;
      end else if (hs) begin
        if (beat_count != CNT_SAT) beat_count <= beat_count + 1'b1;
        if (tlast && (pkt_count != CNT_SAT)) pkt_count <= pkt_count + 1'b1;
        byte_count <= byte_nxt;
      end
    end
  end

endmodule

// File: rtl/axi_stream_checker.sv
// rtl/axi_stream_checker.sv - passive multi-channel stream protocol checker and counters
// Inputs : aclk, areset (sync, active-high), clr, mon (monitor view of NUM_CH streams).
// Outputs: err_flags [c*5 +: 5], err_any, beat/pkt/byte_count [c*CNT_W +: CNT_W], in_packet.
module axi_stream_checker
  import axi_stream_checker_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int BYTE_W        = 4,
  parameter int CNT_W         = 32,
  parameter int MAX_STALL     = 16,
  parameter int MAX_PKT_BEATS = 256
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      clr,
  axi_stream_checker_if.monitor     mon,
  output logic [NUM_CH*ERR_W-1:0]   err_flags,
  output logic                      err_any,
  output logic [NUM_CH*CNT_W-1:0]   beat_count,
  output logic [NUM_CH*CNT_W-1:0]   pkt_count,
  output logic [NUM_CH*CNT_W-1:0]   byte_count,
  output logic [NUM_CH-1:0]         in_packet
);

  logic [NUM_CH*ERR_W-1:0] err_nxt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    axi_stream_checker_ch #(
      .BYTE_W        (BYTE_W),
      .CNT_W         (CNT_W),
      .MAX_STALL     (MAX_STALL),
      .MAX_PKT_BEATS (MAX_PKT_BEATS)
    ) u_ch (
      .aclk          (aclk),
      .areset        (areset),
      .clr           (clr),
      .tvalid        (mon.tvalid[c]),
      .tready        (mon.tready[c]),
      .tdata         (mon.tdata[c*8*BYTE_W +: 8*BYTE_W]),
      .tkeep         (mon.tkeep[c*BYTE_W +: BYTE_W]),
      .tstrb         (mon.tstrb[c*BYTE_W +: BYTE_W]),
      .tlast         (mon.tlast[c]),
      .err_flags     (err_flags[c*ERR_W +: ERR_W]),
      .err_flags_nxt (err_nxt[c*ERR_W +: ERR_W]),
      .beat_count    (beat_count[c*CNT_W +: CNT_W]),
      .pkt_count     (pkt_count[c*CNT_W +: CNT_W]),
      .byte_count    (byte_count[c*CNT_W +: CNT_W]),
      .in_packet     (in_packet[c])
    );
  end

  // Built from next-state flags so err_any moves on the same edge as err_flags.
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_any <= 1'b0;
    end else begin
      err_any <= |err_nxt;
    end
  end

endmodule
